// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames 16 complex samples for a 16-point FFT core.
// It kicks the core, captures its bins (or abandons the frame on timeout),
// clears the core, then streams the bins out with a valid/ready handshake.
module fft_frame_ctrl #(
  parameter int WIDTH        = 36,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_index,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fft_f [0:15],
  output logic             fft_start,
  output logic             fft_reset,
  input  logic [WIDTH-1:0] fft_F [0:15],
  input  logic             fft_done,
  output logic             busy,
  output logic             error
);

  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_KICK,
    S_WAIT,
    S_CAPTURE,
    S_CLEAR,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         wr_idx_q, wr_idx_d;
  logic [3:0]         rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               skip_q, skip_d;
  logic               error_q, error_d;
  logic [WIDTH-1:0]   buf_q [0:15];
  logic [WIDTH-1:0]   res_q [0:15];

  logic in_accept;
  logic out_accept;
  logic capture_en;
  logic timeout_hit;

  assign in_accept   = (state_q == S_FILL) && in_valid;
  assign out_accept  = (state_q == S_DRAIN) && out_ready;
  assign capture_en  = (state_q == S_WAIT) && fft_done;
  // The counter holds completed WAIT cycles; this is the last one allowed.
  assign timeout_hit = (cnt_q == CNT_W'(DONE_TIMEOUT - 1));

  // State register and control registers
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (reset) begin
      state_q  <= S_FILL;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      skip_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      error_q  <= error_d;
    end
  end

  // Next-state and index/counter/flag update logic
  always_comb begin
    // NOTE: every variable gets a default hold value first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q;
    error_d  = error_q;
    unique case (state_q)
      S_FILL: begin
        if (in_accept) begin
          wr_idx_d = wr_idx_q + 4'd1;
          if (wr_idx_q == 4'd15) begin
            wr_idx_d = '0;
            state_d  = S_KICK;
          end
        end
      end
      S_KICK: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done seen on the timeout cycle still wins.
        if (fft_done) begin
          state_d = S_CAPTURE;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          skip_d  = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CAPTURE: state_d = S_CLEAR;
      S_CLEAR: begin
        skip_d  = 1'b0;
        state_d = skip_q ? S_FILL : S_DRAIN;
      end
      S_DRAIN: begin
        if (out_accept) begin
          rd_idx_d = rd_idx_q + 4'd1;
          if (rd_idx_q == 4'd15) begin
            rd_idx_d = '0;
            state_d  = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    in_ready  = (state_q == S_FILL);
    fft_start = (state_q == S_KICK);
    fft_reset = (state_q == S_CLEAR);
    out_valid = (state_q == S_DRAIN);
    out_last  = (state_q == S_DRAIN) && (rd_idx_q == 4'd15);
    busy      = (state_q != S_FILL);
    error     = error_q;
  end

  // Sample buffer written during FILL; result bank loaded when done is seen
  always_ff @(posedge clock) begin
    // NOTE: both banks are reset because fft_f and out_data must read zero
    // out of reset; this makes them flops rather than a RAM macro.
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      if (in_accept) buf_q[wr_idx_q] <= in_data;
      if (capture_en) begin
        for (int i = 0; i < 16; i++) res_q[i] <= fft_F[i];
      end
    end
  end

  assign fft_f     = buf_q;
  assign out_data  = res_q[rd_idx_q];
  assign out_index = rd_idx_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed testbench for fft_frame_ctrl with a behavioural 16-point DFT core.
module tb_fft_frame_ctrl;

  localparam int  W  = 36;
  localparam real PI = 3.14159265358979;

  typedef logic [W-1:0] frame_t [16];
  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  logic         clock, reset;
  logic [W-1:0] in_data;
  logic         in_valid, in_ready;
  logic [W-1:0] out_data;
  logic [3:0]   out_index;
  logic         out_last, out_valid, out_ready;
  logic [W-1:0] fft_f [0:15];
  logic [W-1:0] fft_F [0:15];
  logic         fft_start, fft_reset, fft_done;
  logic         busy, error;

  fft_frame_ctrl #(.WIDTH(W), .DONE_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .fft_f(fft_f), .fft_start(fft_start), .fft_reset(fft_reset),
    .fft_F(fft_F), .fft_done(fft_done),
    .busy(busy), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- helpers ----------------
  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic logic [W-1:0] pack(input int re, input int im);
    logic [17:0] r, i;
    r = re[17:0];
    i = im[17:0];
    return {r, i};
  endfunction

  function automatic int re_of(input logic [W-1:0] w);
    return int'($signed(w[W-1:W/2]));
  endfunction

  function automatic int im_of(input logic [W-1:0] w);
    return int'($signed(w[W/2-1:0]));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic dft(input frame_t x, output frame_t y);
    real sr, si, ang, xr, xi;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        xr  = real'(re_of(x[n]));
        xi  = real'(im_of(x[n]));
        ang = 2.0 * PI * real'(k * n) / 16.0;
        sr  = sr + xr * $cos(ang) + xi * $sin(ang);
        si  = si + xi * $cos(ang) - xr * $sin(ang);
      end
      y[k] = pack(rnd(sr), rnd(si));
    end
  endtask

  // ---------------- FFT core model ----------------
  // Samples start at an edge, raises done four edges later, holds it until
  // its reset pulse. When core_en is 0 it ignores start (stuck core).
  bit     core_en;
  bit     core_busy;
  int     core_cnt;
  frame_t core_x, core_y;

  always @(posedge clock) begin
    if (reset || fft_reset) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      fft_done  <= 1'b0;
      if (reset) for (int k = 0; k < 16; k++) fft_F[k] <= '0;
    end else if (fft_start) begin
      if (core_en) begin
        for (int k = 0; k < 16; k++) core_x[k] = fft_f[k];
        dft(core_x, core_y);
        for (int k = 0; k < 16; k++) fft_F[k] <= core_y[k];
        core_busy <= 1'b1;
        core_cnt  <= 0;
      end
    end else if (core_busy) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 3) begin
        fft_done  <= 1'b1;
        core_busy <= 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int    cyc = 0;
  beat_t beats[$];
  int    beat_edges[$];
  int    acc_edges[$];
  int    start_edges[$];
  int    ov_rise[$];
  int    err_rise[$];
  int    clear_cnt  = 0;
  int    ready_viol = 0;
  bit    prev_ov = 1'b0, prev_err = 1'b0;

  always @(posedge clock) cyc++;

  // Handshakes observed at the negedge complete at the following posedge.
  always @(negedge clock) begin
    if (in_valid && in_ready) acc_edges.push_back(cyc + 1);
    if (out_valid && out_ready) begin
      beats.push_back({out_data, out_index, out_last});
      beat_edges.push_back(cyc + 1);
    end
    if (fft_start) start_edges.push_back(cyc);
    if (fft_reset) clear_cnt++;
    if (out_valid && !prev_ov) ov_rise.push_back(cyc);
    if (error && !prev_err) err_rise.push_back(cyc);
    if (busy && in_ready) ready_viol++;
    prev_ov  = out_valid;
    prev_err = error;
  end

  // ---------------- consumer ready driver ----------------
  bit rdy_toggle = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = rdy_toggle ? ~out_ready : 1'b1;
    end
  end

  // ---------------- stimulus tasks ----------------
  frame_t imp, dc, ramp, imp_exp, dc_exp, ramp_exp;
  int     nostall_base;

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_frame(input frame_t s, input bit rnd_v, input int count);
    int n = 0;
    int guard = 0;
    while (n < count && guard < 1000) begin
      @(posedge clock);
      #1;
      in_data  = s[n];
      in_valid = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (in_valid && in_ready) n++;
      guard++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (n !== count) begin
      n_fail++;
      $display("FAIL send_frame: accepted %0d samples, required %0d", n, count);
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (beats.size() < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (beats.size() < target) begin
      n_fail++;
      $display("FAIL wait_beats: got %0d beats, required %0d", beats.size(), target);
    end
  endtask

  // Number of bins in beats[base..base+15] that differ from exp beyond tol,
  // or carry the wrong index/last flag.
  function automatic int frame_errs(input int base, input frame_t exp, input int tol);
    int e = 0;
    beat_t b;
    if (beats.size() < base + 16) return 16;
    for (int i = 0; i < 16; i++) begin
      b = beats[base + i];
      if (b.idx !== 4'(i) || b.last !== (i == 15) ||
          iabs(re_of(b.data) - re_of(exp[i])) > tol ||
          iabs(im_of(b.data) - im_of(exp[i])) > tol) e++;
    end
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bit f_nz = 1'b0;
    do_reset();
    @(negedge clock);
    n_checks++;
    if ({in_ready, out_valid, out_last, fft_start, fft_reset, busy, error} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 1000000",
               {in_ready, out_valid, out_last, fft_start, fft_reset, busy, error});
    end
    n_checks++;
    if (out_index !== 4'd0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out: index %0d data %h, required 0 / 0", out_index, out_data);
    end
    for (int i = 0; i < 16; i++) if (fft_f[i] !== '0) f_nz = 1'b1;
    n_checks++;
    if (f_nz) begin
      n_fail++;
      $display("FAIL reset_fft_f: nonzero word present, required all 0");
    end
  endtask

  task automatic test_impulse();
    int b0 = beats.size();
    int e, lasts = 0;
    send_frame(imp, 1'b0, 16);
    wait_beats(b0 + 16, 200);
    e = frame_errs(b0, imp_exp, 2);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL impulse_bins: %0d bad bins, required 0", e);
    end
    for (int i = 0; i < 16 && b0 + i < beats.size(); i++) if (beats[b0 + i].last) lasts++;
    n_checks++;
    if (lasts !== 1) begin
      n_fail++;
      $display("FAIL impulse_last_count: %0d, required 1", lasts);
    end
  endtask

  task automatic test_dc();
    int b0 = beats.size();
    int e;
    send_frame(dc, 1'b0, 16);
    wait_beats(b0 + 16, 200);
    e = frame_errs(b0, dc_exp, 2);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL dc_bins: %0d bad bins, required 0", e);
    end
  endtask

  task automatic test_latency();
    int b0 = beats.size(), s0 = start_edges.size(), o0 = ov_rise.size();
    int c0 = clear_cnt;
    int e0, lat, e;
    send_frame(ramp, 1'b0, 16);
    e0 = acc_edges[$];
    wait_beats(b0 + 16, 200);
    repeat (4) @(negedge clock);
    n_checks++;
    if (start_edges.size() - s0 !== 1 || clear_cnt - c0 !== 1) begin
      n_fail++;
      $display("FAIL pulse_width: start %0d cycles, reset %0d cycles, required 1 / 1",
               start_edges.size() - s0, clear_cnt - c0);
    end
    lat = (ov_rise.size() > o0) ? ov_rise[o0] - e0 : -1;
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL first_valid_latency: %0d cycles, required 8", lat);
    end
    e = frame_errs(b0, ramp_exp, 0);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL ramp_bins: %0d bad bins, required 0", e);
    end
    n_checks++;
    if (beats.size() < b0 + 16 || beat_edges[b0 + 15] - beat_edges[b0] !== 15) begin
      n_fail++;
      $display("FAIL drain_duration: beats not on 16 consecutive cycles");
    end
    nostall_base = b0;
  endtask

  task automatic test_back_to_back();
    int b0 = beats.size(), a0 = acc_edges.size();
    int period, total, e;
    send_frame(imp, 1'b0, 16);
    send_frame(dc, 1'b0, 16);
    wait_beats(b0 + 32, 300);
    repeat (4) @(negedge clock);
    period = (acc_edges.size() > a0 + 16) ? acc_edges[a0 + 16] - acc_edges[a0] : -1;
    total  = (beats.size() >= b0 + 32) ? beat_edges[b0 + 31] - acc_edges[a0] + 1 : -1;
    n_checks++;
    if (period !== 40 || total !== 80) begin
      n_fail++;
      $display("FAIL back_to_back_cycles: period %0d total %0d, required 40 / 80", period, total);
    end
    e = frame_errs(b0, imp_exp, 2) + frame_errs(b0 + 16, dc_exp, 2);
    n_checks++;
    if (e !== 0 || beats.size() !== b0 + 32) begin
      n_fail++;
      $display("FAIL back_to_back_data: %0d bad bins, %0d beats, required 0 / 32",
               e, beats.size() - b0);
    end
  endtask

  task automatic test_backpressure();
    int b0 = beats.size(), v0 = ready_viol;
    int e = 0;
    rdy_toggle = 1'b1;
    send_frame(ramp, 1'b1, 16);
    wait_beats(b0 + 16, 400);
    repeat (6) @(negedge clock);
    rdy_toggle = 1'b0;
    for (int i = 0; i < 16; i++)
      if (b0 + i >= beats.size() || beats[b0 + i] !== beats[nostall_base + i]) e++;
    n_checks++;
    if (e !== 0 || beats.size() !== b0 + 16) begin
      n_fail++;
      $display("FAIL backpressure_data: %0d bins differ, %0d beats, required 0 / 16",
               e, beats.size() - b0);
    end
    n_checks++;
    if (ready_viol !== v0) begin
      n_fail++;
      $display("FAIL in_ready_while_busy: %0d cycles, required 0", ready_viol - v0);
    end
  endtask

  task automatic test_timeout();
    int s0 = start_edges.size(), r0 = err_rise.size(), b0 = beats.size();
    int c0 = clear_cnt;
    int k = 0, dly, e;
    core_en = 1'b0;
    send_frame(imp, 1'b0, 16);
    while (!(err_rise.size() > r0 && in_ready) && k < 60) begin
      @(negedge clock);
      k++;
    end
    repeat (5) @(negedge clock);
    // error is first seen 16 sampled cycles after the start cycle: 15 full
    // cycles follow the start pulse before the flag register sets.
    dly = (err_rise.size() > r0 && start_edges.size() > s0) ? err_rise[r0] - start_edges[s0] : -1;
    n_checks++;
    if (dly !== 16) begin
      n_fail++;
      $display("FAIL timeout_delay: %0d, required 16", dly);
    end
    n_checks++;
    if (clear_cnt - c0 !== 1 || beats.size() !== b0) begin
      n_fail++;
      $display("FAIL timeout_actions: reset pulses %0d beats %0d, required 1 / 0",
               clear_cnt - c0, beats.size() - b0);
    end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_recover: in_ready %b busy %b error %b, required 1 0 1",
               in_ready, busy, error);
    end
    core_en = 1'b1;
    b0 = beats.size();
    send_frame(dc, 1'b0, 16);
    wait_beats(b0 + 16, 200);
    e = frame_errs(b0, dc_exp, 2);
    n_checks++;
    if (e !== 0 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL after_timeout_frame: %0d bad bins error %b, required 0 / 1", e, error);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit f_nz = 1'b0;
    int b0, e;
    send_frame(ramp, 1'b0, 7);
    do_reset();
    @(negedge clock);
    for (int i = 0; i < 16; i++) if (fft_f[i] !== '0) f_nz = 1'b1;
    n_checks++;
    if (f_nz || error !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_fill_reset_state: fft_f nonzero %b error %b in_ready %b, required 0 0 1",
               f_nz, error, in_ready);
    end
    b0 = beats.size();
    send_frame(imp, 1'b0, 16);
    wait_beats(b0 + 16, 200);
    e = frame_errs(b0, imp_exp, 2);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL mid_fill_impulse: %0d bad bins, required 0", e);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    core_en  = 1'b1;
    for (int n = 0; n < 16; n++) begin
      imp[n]     = (n == 0) ? pack(1000, 0) : '0;
      imp_exp[n] = pack(1000, 0);
      dc[n]      = pack(100, 0);
      dc_exp[n]  = (n == 0) ? pack(1600, 0) : '0;
      ramp[n]    = pack(50 * n - 300, 20 * n + 5);
    end
    dft(ramp, ramp_exp);

    test_reset();
    test_impulse();
    test_dc();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_fill();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
